divider_nb: RTL

DIVIDER_NB -- requirements
Module: divider_nb

---
 rtl/divider_nb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/divider_nb.sv
// divider_nb: multi-cycle restoring divider, one quotient bit per RUN cycle.
// Flow: IDLE/DONE --start--> RUN (nb steps) --> FIX (sign fix-up) --> DONE.
// A zero divisor skips RUN and FIX and goes straight to DONE.
// Optional feature macro DIVIDER_SIGNED_EN: when defined, operands and
// results are two's complement. When undefined, operands are unsigned and
// FIX only copies the result out.
module divider_nb #(
  parameter int nb = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [nb-1:0] dividend,
  input  logic [nb-1:0] divisor,
  output logic [nb-1:0] quotient,
  output logic [nb-1:0] remainder,
  output logic          ready,
  output logic          div_by_zero
);

  localparam int CW = (nb > 2) ? $clog2(nb) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [nb-1:0] r_rem, r_quo, r_dvs;
  logic [nb-1:0] w_dvd_mag, w_dvs_mag;
  logic [nb:0]   w_sh, w_diff;
  logic          w_borrow, w_unused_msb, w_dvs_zero;

`ifdef DIVIDER_SIGNED_EN
  logic r_neg_q, r_neg_r;
  // The most-negative operand maps to magnitude 2^(nb-1), which still fits
  // as an unsigned nb-bit value.
  assign w_dvd_mag = dividend[nb-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[nb-1]  ? -divisor  : divisor;
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
`endif

  assign w_dvs_zero = (divisor == '0);

  // Restoring step: shift {rem, quo} left one bit, then trial-subtract the
  // divisor. The borrow out of the subtract is the sign of the trial.
  // Because rem < divisor, a kept difference always fits in nb bits, so the
  // top bit of the difference is never needed.
  assign w_sh                 = {r_rem, r_quo[nb-1]};
  assign {w_borrow, w_diff}   = {1'b0, w_sh} - {2'b0, r_dvs};
  assign w_unused_msb         = w_diff[nb];

  // State register; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state: start restarts from any state, including mid-division.
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = w_dvs_zero ? DONE : RUN;
    end else begin
      case (r_state)
        RUN:     if (r_cnt == CW'(nb-1)) w_next = FIX;
        FIX:     w_next = DONE;
        default: w_next = r_state;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    ready = (r_state == DONE);
  end

  // Datapath: operand load, iteration and result registers. The result
  // registers change only on a zero-divisor start or in FIX, so they hold
  // the previous result while a new division runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else if (start) begin
      if (w_dvs_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        r_cnt <= '0;
        r_rem <= '0;
        r_quo <= w_dvd_mag;
        r_dvs <= w_dvs_mag;
`ifdef DIVIDER_SIGNED_EN
        r_neg_q <= dividend[nb-1] ^ divisor[nb-1];
        r_neg_r <= dividend[nb-1];
`endif
      end
    end else begin
      case (r_state)
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_quo <= {r_quo[nb-2:0], ~w_borrow};
          r_rem <= w_borrow ? w_sh[nb-1:0] : w_diff[nb-1:0];
        end
        FIX: begin
`ifdef DIVIDER_SIGNED_EN
          // Most-negative / -1 wraps back to most-negative here by design.
          quotient  <= r_neg_q ? -r_quo : r_quo;
          remainder <= r_neg_r ? -r_rem : r_rem;
`else
          quotient  <= r_quo;
          remainder <= r_rem;
`endif
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
